// File: rtl/cdb_broadcaster.sv
// Common data bus transmit end: round-robin picks up to CDB_LANES results from
// N_FU writeback ports and broadcasts them as registered cdb lanes.
// Latency 1 cycle; no backpressure on cdb, ungranted FUs hold their result.

`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef CDB_SIZE
`define CDB_SIZE 4
`endif

package cdb_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } exception_t;

  typedef union packed {
    logic [31:0] raw;
    struct packed {
      logic [27:0] target;
      logic [3:0]  flags;
    } br;
  } cdb_union_data_t;

  typedef struct packed {
    logic                         valid;
    logic [$clog2(`ROB_SIZE)-1:0] reorder;
    logic [31:0]                  value;
    cdb_union_data_t              data;
    exception_t                   ex;
  } cdb_packet_t;

endpackage

module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int N_FU      = 6,
  parameter int CDB_LANES = `CDB_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  cdb_packet_t       fu_result [N_FU],
  output logic [N_FU-1:0]   fu_ready,
  output cdb_packet_t       cdb [CDB_LANES],
  output logic              busy
);

  // Pointer, lane-index, grant-count and request-count widths.
  localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int LW = (CDB_LANES > 1) ? $clog2(CDB_LANES) : 1;
  localparam int CW = $clog2(CDB_LANES + 1);
  localparam int RW = $clog2(N_FU + 1);

  cdb_packet_t       lanes_q [CDB_LANES];
  cdb_packet_t       lanes_d [CDB_LANES];
  logic [PW-1:0]     rr_ptr_q;
  logic [PW-1:0]     rr_ptr_d;
  logic [PW-1:0]     last_idx;
  logic              any_grant;
  logic [PW:0]       scan_idx;
  logic [CW-1:0]     grant_cnt;
  logic [RW-1:0]     req_cnt;

  // Scan from rr_ptr with wrap; the k-th requester found fills lane k until lanes run out.
  always_comb begin
    fu_ready  = '0;
    lanes_d   = '{default: '0};
    grant_cnt = '0;
    last_idx  = rr_ptr_q;
    any_grant = 1'b0;
    scan_idx  = '0;
    for (int j = 0; j < N_FU; j++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(j);
      if (scan_idx >= (PW+1)'(N_FU)) begin
        scan_idx = scan_idx - (PW+1)'(N_FU);
      end
      if (rst && !flush && fu_result[scan_idx[PW-1:0]].valid &&
          (grant_cnt < CW'(CDB_LANES))) begin
        fu_ready[scan_idx[PW-1:0]]   = 1'b1;
        lanes_d[grant_cnt[LW-1:0]]   = fu_result[scan_idx[PW-1:0]];
        grant_cnt                    = grant_cnt + CW'(1);
        last_idx                     = scan_idx[PW-1:0];
        any_grant                    = 1'b1;
      end
    end
  end

  // Busy flags an oversubscribed cycle; pointer moves past the last granted FU.
  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < N_FU; i++) begin
      req_cnt = req_cnt + RW'(fu_result[i].valid);
    end
    busy = (req_cnt > RW'(CDB_LANES)) && rst && !flush;
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PW'(N_FU - 1)) ? '0 : last_idx + PW'(1);
    end
  end

  // Register the broadcast lanes and the round-robin pointer; reset clears in-flight lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lanes_q  <= '{default: '0};
      rr_ptr_q <= '0;
    end else begin
      lanes_q  <= lanes_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign cdb = lanes_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: hand-written vector table for the directed corner
// cases, then randomized traffic checked against a queue-based reference model.
module tb_cdb_broadcaster;
  import cdb_pkg::*;

  localparam int N = 6;
  localparam int L = 4;
  localparam int PB = $bits(cdb_packet_t);

  logic        clk;
  logic        rst;
  logic        flush;
  cdb_packet_t fu_result [N];
  logic [N-1:0] fu_ready;
  cdb_packet_t cdb [L];
  logic        busy;

  int n_cmp;
  int n_bad;

  // Reference model state
  int          m_rr;
  cdb_packet_t m_cdb [L];
  logic [N-1:0] pending;

  typedef struct {
    logic       r;
    logic       f;
    logic [5:0] mask;
    int         special;
    logic [5:0] ready;
    logic       busy;
  } vec_t;

  vec_t tab[21];

  cdb_broadcaster #(.N_FU(N), .CDB_LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .fu_result(fu_result),
    .fu_ready (fu_ready),
    .cdb      (cdb),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic f, logic [5:0] mask, int sp,
                              logic [5:0] rdy, logic b);
    vec_t v;
    v.r = r; v.f = f; v.mask = mask; v.special = sp; v.ready = rdy; v.busy = b;
    return v;
  endfunction

  function automatic cdb_packet_t rand_pkt();
    cdb_packet_t p;
    p.valid     = 1'b1;
    p.reorder   = 5'($urandom);
    p.value     = $urandom;
    p.data.raw  = $urandom;
    p.ex.valid  = 1'($urandom);
    p.ex.cause  = 5'($urandom);
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after posedge, check at negedge, advance model.
  task automatic step(input logic r, input logic f, input logic [5:0] mask,
                      input int special, input bit use_tab,
                      input logic [5:0] t_ready, input logic t_busy, input int tag);
    int           order[$];
    logic [N-1:0] exp_ready;
    logic         exp_busy;
    cdb_packet_t  nl [L];
    int           last;
    rst   = r;
    flush = f;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (!pending[i]) fu_result[i] = rand_pkt();
        fu_result[i].valid = 1'b1;
      end else begin
        fu_result[i] = '0;
      end
    end
    if (special == 1) begin
      fu_result[2].reorder  = 5'd5;
      fu_result[2].value    = 32'hDEADBEEF;
      fu_result[2].data.raw = '0;
      fu_result[2].ex       = '0;
    end
    if (special == 2) begin
      fu_result[5].ex.valid = 1'b1;
      fu_result[5].ex.cause = 5'h0D;
    end

    // Model: requesters in scan order starting at the pointer, first L win.
    for (int j = 0; j < N; j++) begin
      if (mask[(m_rr + j) % N]) order.push_back((m_rr + j) % N);
    end
    exp_ready = '0;
    last = -1;
    for (int k = 0; k < L; k++) nl[k] = '0;
    if (r && !f) begin
      for (int k = 0; k < order.size() && k < L; k++) begin
        exp_ready[order[k]] = 1'b1;
        nl[k] = fu_result[order[k]];
        last = order[k];
      end
    end
    exp_busy = r && !f && (order.size() > L);

    @(negedge clk);
    if (use_tab) begin
      chk($sformatf("tab%0d fu_ready", tag), 128'(fu_ready), 128'(t_ready));
      chk($sformatf("tab%0d busy", tag), 128'(busy), 128'(t_busy));
    end else begin
      chk($sformatf("rnd%0d fu_ready", tag), 128'(fu_ready), 128'(exp_ready));
      chk($sformatf("rnd%0d busy", tag), 128'(busy), 128'(exp_busy));
    end
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s%0d cdb[%0d]", use_tab ? "tab" : "rnd", tag, k),
          128'(PB'(cdb[k])), 128'(PB'(m_cdb[k])));
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) pending[i] = mask[i] && !exp_ready[i] && r && !f;
    if (!r) begin
      for (int k = 0; k < L; k++) m_cdb[k] = '0;
      m_rr = 0;
    end else begin
      for (int k = 0; k < L; k++) m_cdb[k] = nl[k];
      if (last >= 0) m_rr = (last + 1) % N;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_rr = 0;
    pending = '0;
    for (int k = 0; k < L; k++) m_cdb[k] = '0;

    //           rst   flush  mask    sp  ready   busy
    tab[0]  = mk(1'b0, 1'b0, 6'h3F, 0, 6'h00, 1'b0); // reset with all valid
    tab[1]  = mk(1'b0, 1'b0, 6'h3F, 0, 6'h00, 1'b0);
    tab[2]  = mk(1'b1, 1'b0, 6'h3F, 0, 6'h0F, 1'b1); // saturation, rr->4
    tab[3]  = mk(1'b1, 1'b0, 6'h3F, 0, 6'h33, 1'b1); // FU4,5,0,1, rr->2
    tab[4]  = mk(1'b1, 1'b0, 6'h3F, 0, 6'h3C, 1'b1); // FU2..5, rr->0
    tab[5]  = mk(1'b1, 1'b0, 6'h03, 0, 6'h03, 1'b0); // drain FU0,1, rr->2
    tab[6]  = mk(1'b1, 1'b0, 6'h04, 1, 6'h04, 1'b0); // single FU2, rr->3
    tab[7]  = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0); // FU2 on lane 0
    tab[8]  = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0); // all invalid again
    tab[9]  = mk(1'b1, 1'b0, 6'h03, 0, 6'h03, 1'b0); // rr 3 -> 2
    tab[10] = mk(1'b1, 1'b1, 6'h03, 0, 6'h00, 1'b0); // flush, lanes of row 9 visible
    tab[11] = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0); // nothing after flush
    tab[12] = mk(1'b1, 1'b0, 6'h3F, 0, 6'h3C, 1'b1); // rr held at 2, ->0
    tab[13] = mk(1'b1, 1'b0, 6'h13, 0, 6'h13, 1'b0); // last FU4, rr->5
    tab[14] = mk(1'b1, 1'b0, 6'h21, 2, 6'h21, 1'b0); // wrap FU5 then FU0, rr->1
    tab[15] = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0); // FU5 lane0 w/ ex, FU0 lane1
    tab[16] = mk(1'b1, 1'b0, 6'h3F, 0, 6'h1E, 1'b1); // 4-lane grant, rr->5
    tab[17] = mk(1'b0, 1'b0, 6'h3F, 0, 6'h00, 1'b0); // reset mid-stream
    tab[18] = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0); // lanes cleared
    tab[19] = mk(1'b1, 1'b0, 6'h3F, 0, 6'h0F, 1'b1); // rr back at 0
    tab[20] = mk(1'b1, 1'b0, 6'h00, 0, 6'h00, 1'b0);

    rst   = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) fu_result[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int v = 0; v < 21; v++) begin
      step(tab[v].r, tab[v].f, tab[v].mask, tab[v].special, 1'b1,
           tab[v].ready, tab[v].busy, v);
    end

    for (int c = 0; c < 400; c++) begin
      logic       r;
      logic       f;
      logic [5:0] m;
      r = ($urandom_range(0, 31) != 0);
      f = ($urandom_range(0, 15) == 0);
      m = pending | 6'($urandom);
      step(r, f, m, 0, 1'b0, 6'h00, 1'b0, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmit end of the common data bus (CDB): collects completed results from N_FU functional-unit writeback ports and broadcasts up to CDB_LANES of them per cycle as cdb_packet_t lanes.
- These lanes are the packets every ROB channel and reservation station snoops to clear busy and capture value/data/ex.
- Round-robin arbitration across FUs; registered output, 1-cycle latency.

Parameters:
- N_FU, 6, number of functional-unit result ports.
- CDB_LANES, `CDB_SIZE, number of CDB lanes driven per cycle; must be >= 1 and <= N_FU.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous reset, active-low: asserted when 0.
- flush  input  1  pipeline flush; synchronous.
- fu_result  input  [N_FU] x cdb_packet_t  per-FU result; the .valid field is the request.
- fu_ready  output  N_FU  per-FU grant; a result is accepted in the cycle fu_result[i].valid && fu_ready[i].
- cdb  output  cdb_packet_t [CDB_LANES]  broadcast lanes: valid, reorder ($clog2(`ROB_SIZE) bits), value (32), data (cdb_union_data_t), ex (exception_t).
- busy  output  1  high in any cycle where more FUs request than lanes are available (at least one requester not granted).

Behaviour:
- Reset (rst==0 at posedge):
  - All cdb lanes become all-zero, including valid=0.
  - Round-robin pointer rr_ptr becomes 0.
  - fu_ready and busy are combinational and are forced to 0 while rst==0.
- Grant is combinational from the current fu_result valids and rr_ptr:
  - Scan FU indices rr_ptr, rr_ptr+1, … mod N_FU.
  - The first CDB_LANES requesters found get fu_ready=1.
  - fu_ready[i] is never 1 when fu_result[i].valid==0.
- Lane order:
  - The k-th granted FU in scan order goes to cdb lane k.
  - Lanes from the grant count up to CDB_LANES-1 are driven all-zero with valid=0. The data fields are zero, not stale.
- Latency:
  - A packet accepted in cycle t appears on cdb in cycle t+1, exactly as presented with valid=1, for exactly one cycle.
  - No backpressure on cdb; every broadcast is final.
- rr_ptr update at posedge, when at least one grant is made:
  - rr_ptr <= (index of last granted FU + 1) mod N_FU.
  - Wrap from N_FU-1 to 0.
  - With no grants, rr_ptr holds.
- FU hold rule:
  - An ungranted FU keeps valid and payload stable until granted.
  - The broadcaster does not buffer ungranted requests.
- busy = (number of valid requests > CDB_LANES) && rst && !flush.
- Flush:
  - In a cycle with flush==1, all fu_ready=0 and no grant is made.
  - Next cycle all cdb lanes are zero/invalid.
  - rr_ptr holds.
  - Lanes already valid in the flush cycle stay valid for that cycle, since they are registered.
  - FUs drop their pending results on flush (FU responsibility).
- Reset mid-operation:
  - Any in-flight registered lanes are cleared at that edge.
  - Requests presented during reset are not accepted.
- Tag uniqueness is not checked; duplicate reorder tags in one cycle are passed through unchanged.
- Exception forwarding: the ex field is copied bit-exact; the broadcaster takes no action on exceptions.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all fu_result.valid=1 -> fu_ready=0, busy=0, all cdb.valid=0, rr_ptr=0.
- Single result: FU2 valid, reorder=5, value=32'hDEADBEEF, ex=0 in cycle t -> fu_ready=6'b000100 in t; in t+1 cdb[0]={valid=1, reorder=5, value=DEADBEEF}, cdb[1..3].valid=0 with zero fields; in t+2 all invalid; rr_ptr=3.
- Saturation, N_FU=6, CDB_LANES=4, all six valid and held until granted:
  - Cycle 0: fu_ready=001111, busy=1, rr_ptr->4.
  - Cycle 1: FU4,5 still valid, FU0..3 issue new results -> fu_ready=110011, lanes next cycle = FU4,FU5,FU0,FU1, rr_ptr->2.
- Flush: FU0,FU1 valid with flush=1 -> fu_ready=0, busy=0, next-cycle cdb all invalid, rr_ptr unchanged; a lane broadcast in the flush cycle itself remains valid that cycle.
- Wrap and exception: rr_ptr=5, FU5 and FU0 valid, FU5 ex.valid=1 -> lanes cdb[0]=FU5 with identical ex bits, cdb[1]=FU0; rr_ptr->1.
- Reset mid-stream: rst=0 in the cycle after a 4-lane grant -> registered lanes cleared at that edge, cdb all invalid next cycle, rr_ptr=0.
